// File: rtl/psm_pkg.sv
// Shared types and defaults for the PSM shift-chain sequencer.
package psm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } psm_ctrl_state_e;

  localparam int PSM_CNT_W = 16;

endpackage

// File: rtl/psm_valid_pipe.sv
// Shadow valid bits for the PSM data chain; bit 0 is stage 1, bit X-1 the tail.
module psm_valid_pipe #(
  parameter int X = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         shift,
  input  logic         clear,
  input  logic         din,
  output logic [X-1:0] vbit,
  output logic         tail
);

  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      vbit <= '0;
    end else if (shift) begin
      vbit[0] <= din;
      for (int i = 1; i < X; i++) begin
        vbit[i] <= vbit[i-1];
      end
    end
  end

  assign tail = vbit[X-1];

endmodule

// File: rtl/psm_shift_ctrl.sv
// Burst sequencer for a PSM partial-sum shift chain (fill, drain, clear, done).
// Defining PSM_SHIFT_ABORT_EN adds i_abort to cut a burst short.
//
// state | meaning
// IDLE  | waiting for i_start
// FILL  | accepting i_len words, shifting when the tail can advance
// DRAIN | pushing bubbles until every shadow valid bit is clear
// CLEAR | one-cycle synchronous clear to the chain
// DONE  | one-cycle completion pulse
module psm_shift_ctrl
  import psm_pkg::*;
#(
  parameter int X     = 3,
  parameter int CNT_W = PSM_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_shift,
  output logic             o_clear,
  output logic             o_out_valid,
  input  logic             i_out_ready,
`ifdef PSM_SHIFT_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_busy,
  output logic             o_done
);

  psm_ctrl_state_e  state_q, state_d;
  logic [CNT_W-1:0] len_q, in_cnt_q;
  logic [X-1:0]     vbit;
  logic             tail, can_advance, abort, last_word;
  logic             shift_w, vpipe_din;

`ifdef PSM_SHIFT_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif

  assign can_advance = ~tail | i_out_ready;
  assign last_word   = (in_cnt_q == len_q - CNT_W'(1));
  assign o_out_valid = tail;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_shift     = shift_w;

  always_comb begin
    state_d    = state_q;
    o_in_ready = 1'b0;
    shift_w    = 1'b0;
    o_clear    = 1'b0;
    o_done     = 1'b0;
    vpipe_din  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = (i_len != '0) ? ST_FILL : ST_CLEAR;
      end
      ST_FILL: begin
        vpipe_din = 1'b1;
        if (abort) begin
          state_d = ST_CLEAR;
        end else begin
          o_in_ready = can_advance;
          shift_w    = i_in_valid & can_advance;
          if (shift_w && last_word) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Exit is judged on the registered bits, so the last bubble shift lands first.
        if (abort) begin
          state_d = ST_CLEAR;
        end else begin
          shift_w = (|vbit) & can_advance;
          if (vbit == '0) state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        o_clear = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      in_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && i_start) begin
        len_q    <= i_len;
        in_cnt_q <= '0;
      end else if (state_q == ST_FILL && shift_w) begin
        in_cnt_q <= in_cnt_q + CNT_W'(1);
      end
    end
  end

  psm_valid_pipe #(.X(X)) u_valid_pipe (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .shift (shift_w),
    .clear (o_clear),
    .din   (vpipe_din),
    .vbit  (vbit),
    .tail  (tail)
  );

endmodule

// File: doc/psm_shift_ctrl.md
Name: psm_shift_ctrl

Overview:
- Sequencer for the partial-sum shift register, an X-stage chain with shift-enable, synchronous clear and no valid tracking.
- Accepts a burst of i_len words from upstream with a valid/ready handshake and drives the chain's shift and clear strobes.
- Keeps a shadow valid bit per stage, so it can present a valid/ready interface at the chain's tail, apply downstream backpressure, drain the chain and clear it.
- Sits beside each PSM shift register in the SAURIA core output path.

Parameters:
X, 3, depth of the controlled shift chain (stages), >=1
CNT_W, 16, width of the burst-length and word counters

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  start-burst pulse; sampled only in IDLE
i_len  in  CNT_W  words in burst; sampled with i_start
i_in_valid  in  1  upstream word valid
o_in_ready  out  1  upstream word accepted when valid&ready
o_shift  out  1  shift enable to chain (combinational)
o_clear  out  1  synchronous clear to chain
o_out_valid  out  1  chain tail holds a valid word
i_out_ready  in  1  downstream accepts tail word
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset: i_clk edge with i_rst=1 forces IDLE, counters=0, valid bits=0. All outputs are 0 at reset, and all registered outputs are 0 in the cycle after reset. Reset mid-burst aborts without a clear pulse; the chain has its own reset.
- States: IDLE, FILL, DRAIN, CLEAR, DONE.
- IDLE: i_start=1 latches len_q=i_len and in_cnt=0.
  - Next state is FILL if i_len!=0, else CLEAR.
  - i_start outside IDLE is ignored.
- can_advance = ~vbit[X] | i_out_ready, where vbit[X] is the tail stage's shadow valid bit.
- FILL:
  - o_in_ready = can_advance.
  - o_shift = i_in_valid & can_advance.
  - Each shift does in_cnt++ and shifts a 1 into vbit[1].
  - When in_cnt reaches len_q-1 and a shift occurs, next state is DRAIN.
- DRAIN:
  - o_in_ready = 0.
  - o_shift = |vbit & can_advance; a 0 is inserted into vbit[1] (a bubble).
  - When all vbit are 0, next state is CLEAR. The check is made on the registered value, after any final shift.
- CLEAR: o_clear=1 for exactly one cycle, then DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- o_out_valid = vbit[X].
  - A tail word is consumed exactly when o_out_valid & i_out_ready; this coincides with o_shift in FILL and DRAIN.
  - A shift with vbit[X]=0 discards the bubble.
- Latency: the first accepted word reaches the tail after X shifts, not X cycles. Bubbles do not count.
- o_shift and o_clear are never both 1.
- in_cnt wraps never: len_q <= 2^CNT_W-1.
- Shadow valid bits shift only when o_shift=1. They mirror the chain 1:1 and are cleared in CLEAR.
- Sustained rate is one word per cycle when i_in_valid=1 and i_out_ready=1.

Optional Feature:
- Macro PSM_SHIFT_ABORT_EN adds input port i_abort (1 bit).
- With the macro defined:
  - i_abort=1 in FILL or DRAIN forces next state CLEAR, discarding the chain contents.
  - o_in_ready and o_shift are 0 in that cycle; o_done still pulses.
  - i_abort is ignored in IDLE, CLEAR and DONE, and loses to i_rst.
- Without it: the port is absent; bursts always complete via DRAIN.

Decomposition:
- Package psm_pkg:
  - psm_ctrl_state_e enum with the 5 states.
  - Default CNT_W constant.
- Sub-module psm_valid_pipe: X-bit shadow valid shift register with shift, clear and din inputs, and vector and tail outputs. It is synchronous-reset, unlike the data chain.
- Controller FSM and counters stay in psm_shift_ctrl.

Test Plan:
- X=3, len=5, in_valid=1, out_ready=1:
  - 5 consecutive o_shift cycles; o_out_valid first rises after the 3rd shift.
  - DRAIN issues 3 shifts, then o_clear for 1 cycle, then o_done on the next cycle.
  - 5 tail handshakes in total.
- X=3, len=4, out_ready low from the 4th shift onward for 6 cycles:
  - o_in_ready=0 and o_shift=0 while vbit[3]=1.
  - Flow resumes on out_ready=1; no word lost or duplicated; 4 handshakes.
- len=0: IDLE, then 1 cycle CLEAR with o_clear=1, then DONE; zero shifts.
- i_start pulsed during FILL with i_len=9: ignored; the burst ends after the original len; o_busy stays 1 until DONE.
- i_rst asserted during the 2nd FILL shift: the next cycle has IDLE, all outputs 0 and vbit=0; a new start with len=2 completes normally.
- With PSM_SHIFT_ABORT_EN, i_abort in DRAIN at X=4:
  - o_shift=0 in the abort cycle.
  - CLEAR the next cycle, then o_done; remaining tail words are not presented.
